alu_muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for the 8-bit ALU: unsigned shift-add multiply and restoring divide.
//  One iteration per clock, over a shared accumulator/shift datapath.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_muldiv_step.sv | 34 +++
 rtl/alu_muldiv_seq.sv | 126 ++++++++++++
 tb/tb_alu_muldiv_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, sequencer state encoding and datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
module alu_muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] acc_hi_next,
  output logic [WIDTH-1:0] acc_lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;

  always_comb begin
    // Multiply keeps the carry out of acc_hi so it shifts back into the top bit.
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    if (op == OP_MUL) begin
      acc_hi_next = sum[WIDTH:1];
      acc_lo_next = {sum[0], acc_lo[WIDTH-1:1]};
    end else if (shifted >= {1'b0, operand_b}) begin
      acc_hi_next = WIDTH'(shifted - {1'b0, operand_b});
      acc_lo_next = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      acc_hi_next = shifted[WIDTH-1:0];
      acc_lo_next = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL/DIV sequencer with start/done handshake; results held until the next op.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] step_hi, step_lo;

  // Multiplication is commutative, so a sits in acc_lo for both ops and b is the step operand.
  alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op          (op_q),
    .acc_hi      (acc_hi_q),
    .acc_lo      (acc_lo_q),
    .operand_b   (opb_q),
    .acc_hi_next (step_hi),
    .acc_lo_next (step_lo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dbz_pend_d = dbz_pend_q;
    opb_d      = opb_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    dbz_d      = dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d     = op;
          opb_d    = b;
          acc_hi_d = '0;
          acc_lo_d = a;
          state_d  = ST_RUN;
          // A zero divisor spends a single RUN cycle so done lands after the first edge.
          if (op == OP_DIV && b == '0) begin
            dbz_pend_d = 1'b1;
            cnt_d      = CNT_W'(1);
          end else begin
            dbz_pend_d = 1'b0;
            cnt_d      = CNT_W'(WIDTH);
          end
        end
      end
      ST_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          if (dbz_pend_q) begin
            res_hi_d = acc_lo_q;
            res_lo_d = '1;
            dbz_d    = 1'b1;
          end else begin
            res_hi_d = step_hi;
            res_lo_d = step_lo;
            dbz_d    = 1'b0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      dbz_pend_q <= 1'b0;
      opb_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dbz_pend_q <= dbz_pend_d;
      opb_q      <= opb_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign result_hi   = res_hi_q;
  assign result_lo   = res_lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed and random checks of alu_muldiv_seq against an arithmetic reference model.
module tb_alu_muldiv_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_hi, result_lo;

  int n_checks = 0;
  int n_pass   = 0;

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Returns {div_by_zero, result_hi, result_lo} from plain arithmetic.
  function automatic logic [2*W:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    if (o == 1'b0) begin
      p = int'(x) * int'(y);
      return {1'b0, p[2*W-1:0]};
    end else if (y == '0) begin
      return {1'b1, x, 8'hFF};
    end else begin
      p = (int'(x) % int'(y)) * 256 + (int'(x) / int'(y));
      return {1'b0, p[2*W-1:0]};
    end
  endfunction

  function automatic logic [31:0] outs();
    return {15'd0, div_by_zero, result_hi, result_lo};
  endfunction

  // Called on a negedge while IDLE; returns on the negedge after the DONE->IDLE edge.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W:0] e;
    int lat;
    e   = model(o, x, y);
    lat = (o == 1'b1 && y == '0) ? 1 : W;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_after_accept", 32'(done), 32'd0);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk("done_early", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("result", outs(), 32'(e));
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
    chk("result_held", outs(), 32'(e));
    $display("op=%s a=%0d b=%0d -> hi=%02h lo=%02h dbz=%0b (exp hi=%02h lo=%02h dbz=%0b)",
             o ? "DIV" : "MUL", x, y, result_hi, result_lo, div_by_zero,
             e[2*W-1:W], e[W-1:0], e[2*W]);
  endtask

  initial begin
    logic         ro;
    logic [W-1:0] ra, rb;

    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_results", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 8'd13, 8'd11);
    run_op(1'b0, 8'd255, 8'd255);
    run_op(1'b0, 8'd0, 8'd200);
    run_op(1'b1, 8'd200, 8'd7);
    run_op(1'b1, 8'd5, 8'd9);
    run_op(1'b1, 8'd7, 8'd0);
    run_op(1'b1, 8'd9, 8'd3);

    // start held high through RUN and DONE with different operands
    start = 1'b1; op = 1'b0; a = 8'd13; b = 8'd11;
    @(negedge clk);
    a = 8'd1; b = 8'd1;
    repeat (7) @(negedge clk);
    @(negedge clk);
    chk("ignore_done", 32'(done), 32'd1);
    chk("ignore_result", outs(), 32'h0000_008F);
    @(negedge clk);
    chk("ignore_idle_busy", 32'(busy), 32'd0);
    chk("ignore_held", outs(), 32'h0000_008F);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept", 32'(busy), 32'd1);
    repeat (7) @(negedge clk);
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_result", outs(), 32'h0000_0001);
    @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);
    $display("op=MUL a=1 b=1 (back-to-back) -> hi=%02h lo=%02h dbz=%0b", result_hi, result_lo, div_by_zero);

    // reset in the middle of a multiply
    start = 1'b1; op = 1'b0; a = 8'd13; b = 8'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_results", outs(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'({busy, done}), 32'd0);
    end
    $display("op=MUL a=13 b=11 aborted by reset -> hi=%02h lo=%02h", result_hi, result_lo);
    run_op(1'b0, 8'd3, 8'd4);

    for (int k = 0; k < 24; k++) begin
      ro = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_op(ro, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
